// File: rtl/ltc_adc_if.sv
// Bus between the LTC ADC emulator and whatever drives it: run/pattern controls
// in one direction, serial lanes, clocks and status in the other.
`timescale 1ns/1ps
interface ltc_adc_if #(
  parameter int N_CH     = 2,
  parameter int LANES    = 2,
  parameter int SAMPLE_W = 16
);
  logic                       enable;
  logic [1:0]                 mode;
  logic [15:0]                pattern;
  logic [N_CH*LANES-1:0]      lane_o;
  logic                       dco_o;
  logic                       fr_o;
  logic                       frame_start_o;
  logic [N_CH*SAMPLE_W-1:0]   sample_o;
  logic [31:0]                frame_cnt_o;
  logic                       busy_o;

  // master is the controlling side (receiver test harness), slave is the emulator
  modport master (
    output enable, mode, pattern,
    input  lane_o, dco_o, fr_o, frame_start_o, sample_o, frame_cnt_o, busy_o
  );

  modport slave (
    input  enable, mode, pattern,
    output lane_o, dco_o, fr_o, frame_start_o, sample_o, frame_cnt_o, busy_o
  );
endinterface

// File: rtl/ltc_adc_emulator.sv
// Multi-channel LTC-style serial ADC emulator: frame clock, bit clock and MSB-first
// data lanes interleaved across LANES, with fixed/ramp/alternating/PRBS words.
`timescale 1ns/1ps
module ltc_adc_emulator #(
  parameter int          N_CH      = 2,
  parameter int          LANES     = 2,
  parameter int          SAMPLE_W  = 16,
  parameter bit          DCO_INV   = 1'b0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic     clk,
  input  logic     rst_n,
  ltc_adc_if.slave bus
);

  localparam int BPF    = SAMPLE_W / LANES;
  localparam int SLOT_W = (BPF > 1) ? $clog2(BPF) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state, state_next;
  logic [SLOT_W-1:0]        slot;
  logic                     load;
  logic                     last_slot;
  logic                     dco;
  logic                     fr;
  logic                     frame_start;
  logic [31:0]              frame_cnt;
  logic [SAMPLE_W-1:0]      ramp;
  logic [N_CH*SAMPLE_W-1:0] sample;
  logic [15:0]              lfsr      [N_CH];
  logic [15:0]              lfsr_next [N_CH];
  logic [SAMPLE_W-1:0]      word_next [N_CH];
  logic [SAMPLE_W-1:0]      shifted   [N_CH];

  function automatic logic [15:0] seed_of(input int c);
    logic [15:0] s;
    s = LFSR_SEED ^ 16'(c);
    if (s == 16'h0000) s = 16'h0001;
    return s;
  endfunction

  // Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    logic fb;
    fb = v[0] ^ v[2] ^ v[3] ^ v[5];
    return {fb, v[15:1]};
  endfunction

  assign last_slot = (slot == SLOT_W'(BPF - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A frame boundary (load) happens on leaving IDLE or on the last slot while still enabled
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.enable) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (last_slot) begin
          if (bus.enable) load = 1'b1;
          else            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      word_next[c] = '0;
      lfsr_next[c] = lfsr_step(lfsr[c]);
      case (bus.mode)
        2'd0: word_next[c] = bus.pattern[SAMPLE_W-1:0];
        2'd1: word_next[c] = ramp + SAMPLE_W'(c);
        2'd2: word_next[c] = frame_cnt[0] ? ~bus.pattern[SAMPLE_W-1:0]
                                          :  bus.pattern[SAMPLE_W-1:0];
        default: word_next[c] = lfsr[c][SAMPLE_W-1:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot        <= '0;
      dco         <= DCO_INV;
      fr          <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= 32'd0;
      ramp        <= '0;
      sample      <= '0;
      for (int c = 0; c < N_CH; c++) lfsr[c] <= seed_of(c);
    end else begin
      dco         <= ~dco;
      frame_start <= load;
      if (load) begin
        slot      <= '0;
        fr        <= ~fr;
        frame_cnt <= frame_cnt + 32'd1;
        for (int c = 0; c < N_CH; c++) sample[c*SAMPLE_W +: SAMPLE_W] <= word_next[c];
        if (bus.mode == 2'd1) ramp <= ramp + 1'b1;
        if (bus.mode == 2'd3) begin
          for (int c = 0; c < N_CH; c++) lfsr[c] <= lfsr_next[c];
        end
      end else if (state == RUN) begin
        slot <= last_slot ? '0 : slot + 1'b1;
      end
    end
  end

  // Shifting the word left by slot*LANES puts the current slot's bits at the top
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      shifted[c] = sample[c*SAMPLE_W +: SAMPLE_W] << (32'(slot) * LANES);
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      assign bus.lane_o[c*LANES+k] = (state == RUN) & shifted[c][SAMPLE_W-1-k];
    end
  end

  assign bus.dco_o         = dco;
  assign bus.fr_o          = fr;
  assign bus.frame_start_o = frame_start;
  assign bus.sample_o      = sample;
  assign bus.frame_cnt_o   = frame_cnt;
  assign bus.busy_o        = (state == RUN);

endmodule

// File: tb/tb_ltc_adc_emulator.sv
// Directed self-checking bench for ltc_adc_emulator: three instances cover the
// default 2x2 build, a 4-lane build with inverted DCO, and a 12-bit build for ramp wrap.
`timescale 1ns/1ps
module tb_ltc_adc_emulator;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  ltc_adc_if #(.N_CH(2), .LANES(2), .SAMPLE_W(16)) bus_main ();
  ltc_adc_if #(.N_CH(1), .LANES(4), .SAMPLE_W(16)) bus_l4 ();
  ltc_adc_if #(.N_CH(2), .LANES(4), .SAMPLE_W(12)) bus_w12 ();

  ltc_adc_emulator #(.N_CH(2), .LANES(2), .SAMPLE_W(16), .DCO_INV(1'b0), .LFSR_SEED(16'hACE1))
    u_dut_main (.clk(clk), .rst_n(rst_n), .bus(bus_main));

  ltc_adc_emulator #(.N_CH(1), .LANES(4), .SAMPLE_W(16), .DCO_INV(1'b1), .LFSR_SEED(16'hACE1))
    u_dut_l4 (.clk(clk), .rst_n(rst_n), .bus(bus_l4));

  ltc_adc_emulator #(.N_CH(2), .LANES(4), .SAMPLE_W(12), .DCO_INV(1'b0), .LFSR_SEED(16'hACE1))
    u_dut_w12 (.clk(clk), .rst_n(rst_n), .bus(bus_w12));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic en, input logic [1:0] md, input logic [15:0] pat);
    bus_main.enable  = en;
    bus_main.mode    = md;
    bus_main.pattern = pat;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
      else begin
        n_fail++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  logic [7:0] exp_a;
  logic [7:0] exp_b;
  logic [3:0] exp_l4;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_a    = 8'b0000_0010;
    exp_b    = 8'b0000_0011;
    exp_l4   = 4'b1010;
    rst_n    = 1'b0;
    apply_stimulus(1'b0, 2'd0, 16'h0000);
    bus_l4.enable   = 1'b0;
    bus_l4.mode     = 2'd0;
    bus_l4.pattern  = 16'h0000;
    bus_w12.enable  = 1'b0;
    bus_w12.mode    = 2'd0;
    bus_w12.pattern = 16'h0000;

    tick(3);
    check_output("rst_lane",  bus_main.lane_o,        4'h0);
    check_output("rst_fr",    bus_main.fr_o,          1'b0);
    check_output("rst_dco",   bus_main.dco_o,         1'b0);
    check_output("rst_fs",    bus_main.frame_start_o, 1'b0);
    check_output("rst_smp",   bus_main.sample_o,      32'h0);
    check_output("rst_cnt",   bus_main.frame_cnt_o,   32'h0);
    check_output("rst_busy",  bus_main.busy_o,        1'b0);
    check_output("rst_dco_inv", bus_l4.dco_o,         1'b1);

    rst_n = 1'b1;
    tick(1);
    check_output("dco_toggle1", bus_main.dco_o, 1'b1);
    tick(1);
    check_output("dco_toggle2", bus_main.dco_o, 1'b0);
    check_output("idle_lane",   bus_main.lane_o, 4'h0);

    // 4-lane alternating pattern: lane0 carries bits 15,11,7,3
    $display("[TB] 4-lane alternating pattern");
    bus_l4.enable  = 1'b1;
    bus_l4.mode    = 2'd2;
    bus_l4.pattern = 16'hA5F0;
    tick(1);
    check_output("l4_fs",  bus_l4.frame_start_o, 1'b1);
    check_output("l4_w0",  bus_l4.sample_o,      16'hA5F0);
    for (int s = 0; s < 4; s++) begin
      check_output($sformatf("l4_lane0_s%0d", s), bus_l4.lane_o[0], exp_l4[3-s]);
      tick(1);
    end
    check_output("l4_w1",  bus_l4.sample_o, 16'h5A0F);
    bus_l4.enable = 1'b0;
    tick(4);
    check_output("l4_idle", bus_l4.busy_o, 1'b0);

    // fixed pattern 000D, then mid-frame mode change to ramp
    $display("[TB] fixed pattern and ramp");
    apply_stimulus(1'b1, 2'd0, 16'h000D);
    tick(1);
    check_output("t1_fs",   bus_main.frame_start_o, 1'b1);
    check_output("t1_busy", bus_main.busy_o,        1'b1);
    check_output("t1_cnt",  bus_main.frame_cnt_o,   32'd1);
    check_output("t1_fr",   bus_main.fr_o,          1'b1);
    check_output("t1_smp",  bus_main.sample_o,      32'h000D_000D);
    for (int s = 0; s < 8; s++) begin
      check_output($sformatf("t1_lanes_s%0d", s), bus_main.lane_o[1:0],
                   {exp_b[7-s], exp_a[7-s]});
      if (s == 1) check_output("t1_fs_low", bus_main.frame_start_o, 1'b0);
      if (s == 3) apply_stimulus(1'b1, 2'd1, 16'h000D);
      if (s == 7) check_output("t1_smp_held", bus_main.sample_o, 32'h000D_000D);
      tick(1);
    end
    check_output("t2_fs1",  bus_main.frame_start_o, 1'b1);
    check_output("t2_fr1",  bus_main.fr_o,          1'b0);
    check_output("t2_cnt1", bus_main.frame_cnt_o,   32'd2);
    check_output("t2_w1",   bus_main.sample_o,      32'h0001_0000);
    tick(8);
    check_output("t2_w2",   bus_main.sample_o,      32'h0002_0001);
    tick(8);
    check_output("t2_w3",   bus_main.sample_o,      32'h0003_0002);
    apply_stimulus(1'b1, 2'd2, 16'hA5F0);

    // alternating: frame 5 loads with an even count
    $display("[TB] alternating pattern");
    tick(8);
    check_output("t3_w0",    bus_main.sample_o, 32'hA5F0_A5F0);
    check_output("t3_lane0", bus_main.lane_o,   4'b0101);
    tick(8);
    check_output("t3_w1",    bus_main.sample_o, 32'h5A0F_5A0F);
    apply_stimulus(1'b1, 2'd3, 16'hA5F0);

    $display("[TB] PRBS");
    tick(8);
    check_output("t4_w0", bus_main.sample_o, 32'hACE0_ACE1);
    tick(8);
    check_output("t4_w1", bus_main.sample_o, 32'hD670_5670);
    tick(8);
    check_output("t4_w2", bus_main.sample_o, 32'hEB38_AB38);
    tick(8);
    check_output("t4_w3",  bus_main.sample_o,    32'h759C_559C);
    check_output("t4_cnt", bus_main.frame_cnt_o, 32'd10);

    // drop enable at slot 3; the frame still runs to slot 7
    $display("[TB] enable drop mid-frame");
    tick(3);
    apply_stimulus(1'b0, 2'd3, 16'hA5F0);
    tick(1);
    check_output("t5_lane_s4", bus_main.lane_o, 4'b0101);
    check_output("t5_busy_s4", bus_main.busy_o, 1'b1);
    tick(3);
    check_output("t5_busy_s7", bus_main.busy_o, 1'b1);
    tick(1);
    check_output("t5_busy_end", bus_main.busy_o,        1'b0);
    check_output("t5_lane_end", bus_main.lane_o,        4'h0);
    check_output("t5_fs_end",   bus_main.frame_start_o, 1'b0);
    tick(5);
    check_output("t5_cnt_hold", bus_main.frame_cnt_o,   32'd10);
    check_output("t5_fr_hold",  bus_main.fr_o,          1'b0);

    // 12-bit ramp runs through 12'hFFF and wraps
    $display("[TB] 12-bit ramp wrap");
    bus_w12.enable = 1'b1;
    bus_w12.mode   = 2'd1;
    tick(1);
    check_output("w12_w0", bus_w12.sample_o, 24'h001_000);
    tick(4095 * 3);
    check_output("w12_top", bus_w12.sample_o,    24'h000_FFF);
    check_output("w12_cnt", bus_w12.frame_cnt_o, 32'd4096);
    tick(3);
    check_output("w12_wrap", bus_w12.sample_o, 24'h001_000);
    bus_w12.enable = 1'b0;

    // asynchronous reset mid-frame, then PRBS restarts from the seeds
    $display("[TB] reset mid-frame");
    apply_stimulus(1'b1, 2'd3, 16'h0000);
    tick(1);
    check_output("t6_pre", bus_main.sample_o, 32'h3ACE_2ACE);
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t6_lane", bus_main.lane_o,        4'h0);
    check_output("t6_busy", bus_main.busy_o,        1'b0);
    check_output("t6_fs",   bus_main.frame_start_o, 1'b0);
    check_output("t6_cnt",  bus_main.frame_cnt_o,   32'd0);
    check_output("t6_smp",  bus_main.sample_o,      32'h0);
    check_output("t6_fr",   bus_main.fr_o,          1'b0);
    check_output("t6_dco",  bus_main.dco_o,         1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1);
    check_output("t6_restart_fs",  bus_main.frame_start_o, 1'b1);
    check_output("t6_restart_w",   bus_main.sample_o,      32'hACE0_ACE1);
    check_output("t6_restart_cnt", bus_main.frame_cnt_o,   32'd1);
    tick(8);
    check_output("t6_restart_w1",  bus_main.sample_o,      32'hD670_5670);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
